// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS serial configuration writer.
package dds_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    ADDR     = 3'd2,
    DATA     = 3'd3,
    COMMIT   = 3'd4,
    WAIT_END = 3'd5
  } state_e;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_CLEAR = 1'b1;

  // Bit counter width: enough to count up to the longer of the two fields.
  function automatic int unsigned cnt_width(input int unsigned a_w, input int unsigned d_w);
    int unsigned m;
    m = (a_w > d_w) ? a_w : d_w;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dds_sipo.sv
// Serial-in/parallel-out shift register, MSB first, with shift enable and sync clear.
module dds_sipo
  import dds_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_shift) begin
      r_q <= WIDTH'({r_q, i_bit});
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dds_cfg_loader.sv
// Serial command deframer driving the DDS register bank: parallel data plus
// one-hot load (enh) and clear (clrh) strobes.
module dds_cfg_loader
  import dds_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  frame_n,
  input  logic                  bit_vld,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic [NUM_REGS-1:0]   enh,
  output logic [NUM_REGS-1:0]   clrh,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned CNT_W = cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned CMP_W = ADDR_WIDTH + 1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_cmd;
  logic                  w_cmd_ld;
  logic                  w_addr_shift;
  logic                  w_data_shift;
  logic                  w_sipo_clr;
  logic                  w_dout_ld;
  logic                  w_addr_last;
  logic                  w_data_last;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH-1:0] w_data_full;
  logic [NUM_REGS-1:0]   w_onehot;
  logic [NUM_REGS-1:0]   w_enh_nxt;
  logic [NUM_REGS-1:0]   w_clrh_nxt;
  logic                  w_err_nxt;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [NUM_REGS-1:0]   r_enh;
  logic [NUM_REGS-1:0]   r_clrh;
  logic                  r_busy;
  logic                  r_err;

  dds_sipo #(.WIDTH(ADDR_WIDTH)) u_addr_sipo (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (w_sipo_clr),
    .i_shift (w_addr_shift),
    .i_bit   (bit_in),
    .o_q     (w_addr)
  );

  dds_sipo #(.WIDTH(DATA_WIDTH)) u_data_sipo (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (w_sipo_clr),
    .i_shift (w_data_shift),
    .i_bit   (bit_in),
    .o_q     (w_data)
  );

  // Word as it will look once the current (last) data bit is shifted in.
  assign w_data_full = DATA_WIDTH'({w_data, bit_in});
  assign w_addr_last = (r_cnt == CNT_W'(ADDR_WIDTH - 1));
  assign w_data_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_in_range  = ({1'b0, w_addr} < CMP_W'(NUM_REGS));
  assign w_onehot    = NUM_REGS'(1) << w_addr;
  assign w_sipo_clr  = (r_state == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus next values for the registered outputs and datapath controls.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cmd_ld     = 1'b0;
    w_addr_shift = 1'b0;
    w_data_shift = 1'b0;
    w_dout_ld    = 1'b0;
    w_enh_nxt    = '0;
    w_clrh_nxt   = '0;
    w_err_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!frame_n) begin
          w_state_nxt = CMD;
        end
      end

      CMD: begin
        if (frame_n) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end else if (bit_vld) begin
          w_cmd_ld    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ADDR;
        end
      end

      ADDR: begin
        if (frame_n) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end else if (bit_vld) begin
          w_addr_shift = 1'b1;
          if (w_addr_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = DATA;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      DATA: begin
        if (frame_n) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end else if (bit_vld) begin
          w_data_shift = 1'b1;
          if (w_data_last) begin
            w_cnt_nxt   = '0;
            w_dout_ld   = 1'b1;
            w_state_nxt = COMMIT;
            // Strobes are registered, so decode now to land in the COMMIT cycle.
            if (!w_in_range) begin
              w_err_nxt = 1'b1;
            end else if (r_cmd == CMD_CLEAR) begin
              w_clrh_nxt = w_onehot;
            end else begin
              w_enh_nxt = w_onehot;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      COMMIT: begin
        w_state_nxt = WAIT_END;
      end

      WAIT_END: begin
        if (frame_n) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_cmd  <= 1'b0;
      r_dout <= '0;
      r_enh  <= '0;
      r_clrh <= '0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_enh  <= w_enh_nxt;
      r_clrh <= w_clrh_nxt;
      r_err  <= w_err_nxt;
      r_busy <= (w_state_nxt != IDLE);
      if (w_cmd_ld) begin
        r_cmd <= bit_in;
      end
      if (w_dout_ld) begin
        r_dout <= w_data_full;
      end
    end
  end

  assign d_out = r_dout;
  assign enh   = r_enh;
  assign clrh  = r_clrh;
  assign busy  = r_busy;
  assign err   = r_err;

endmodule

// File: tb/tb_dds_cfg_loader.sv
// Directed bench for dds_cfg_loader: a 4-register and a 3-register instance share stimulus.
module tb_dds_cfg_loader;

  logic       clk;
  logic       rstn;
  logic       frame_n;
  logic       bit_vld;
  logic       bit_in;
  logic [7:0] d_out;
  logic [3:0] enh;
  logic [3:0] clrh;
  logic       busy;
  logic       err;
  logic [7:0] d_out3;
  logic [2:0] enh3;
  logic [2:0] clrh3;
  logic       busy3;
  logic       err3;

  int n_cmp;
  int n_mis;
  int n_enh_cyc;
  int n_clrh_cyc;
  int n_err_cyc;
  int n_err3_cyc;
  int n_bad;

  dds_cfg_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_REGS(4)) u_dut (
    .clk(clk), .rstn(rstn), .frame_n(frame_n), .bit_vld(bit_vld), .bit_in(bit_in),
    .d_out(d_out), .enh(enh), .clrh(clrh), .busy(busy), .err(err)
  );

  dds_cfg_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_REGS(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .frame_n(frame_n), .bit_vld(bit_vld), .bit_in(bit_in),
    .d_out(d_out3), .enh(enh3), .clrh(clrh3), .busy(busy3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle tallies of strobe activity and one-hot violations.
  always @(negedge clk) begin
    if (enh != 4'd0)  n_enh_cyc  <= n_enh_cyc + 1;
    if (clrh != 4'd0) n_clrh_cyc <= n_clrh_cyc + 1;
    if (err)          n_err_cyc  <= n_err_cyc + 1;
    if (err3)         n_err3_cyc <= n_err3_cyc + 1;
    if (($countones(enh) > 1) || ($countones(clrh) > 1) || (enh != 4'd0 && clrh != 4'd0) ||
        ($countones(enh3) > 1) || ($countones(clrh3) > 1) || (enh3 != 3'd0 && clrh3 != 3'd0))
      n_bad <= n_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Opens a frame and shifts all 11 bits; returns right after the last bit's edge (COMMIT cycle).
  task automatic send_frame(input logic cmd, input logic [1:0] addr, input logic [7:0] data,
                            input bit gap);
    logic [10:0] word;
    word    = {cmd, addr, data};
    frame_n = 1'b0;
    bit_vld = 1'b0;
    tick();
    for (int i = 10; i >= 0; i--) begin
      bit_vld = 1'b1;
      bit_in  = word[i];
      tick();
      if (gap && i > 0) begin
        bit_vld = 1'b0;
        bit_in  = ~bit_in;
        tick();
      end
    end
    bit_vld = 1'b0;
  endtask

  task automatic end_frame();
    bit_vld = 1'b0;
    tick();
    frame_n = 1'b1;
    tick();
  endtask

  initial begin
    int b_enh;
    int b_clrh;
    int b_err;
    int b_err3;
    logic [10:0] w;

    n_cmp = 0; n_mis = 0;
    n_enh_cyc = 0; n_clrh_cyc = 0; n_err_cyc = 0; n_err3_cyc = 0; n_bad = 0;
    rstn = 1'b1; frame_n = 1'b1; bit_vld = 1'b0; bit_in = 1'b0;
    #3 rstn = 1'b0;
    tick();
    check("rst_dout", d_out, 8'h00);
    check("rst_enh", enh, 4'h0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();

    // Write addr=2 data=A5, continuous bits
    b_enh = n_enh_cyc; b_err = n_err_cyc;
    send_frame(1'b0, 2'd2, 8'hA5, 1'b0);
    check("wr_enh", enh, 4'b0100);
    check("wr_clrh", clrh, 4'b0000);
    check("wr_dout", d_out, 8'hA5);
    check("wr_busy_commit", busy, 1'b1);
    bit_vld = 1'b0;
    tick();
    check("wr_enh_drop", enh, 4'b0000);
    check("wr_busy_wait", busy, 1'b1);
    frame_n = 1'b1;
    tick();
    check("wr_busy_idle", busy, 1'b0);
    check("wr_enh_cycles", 32'(n_enh_cyc - b_enh), 1);
    check("wr_no_err", 32'(n_err_cyc - b_err), 0);

    // Abort after 5 accepted bits, then a full frame
    b_enh = n_enh_cyc; b_clrh = n_clrh_cyc; b_err = n_err_cyc;
    w = {1'b0, 2'd1, 8'h5A};
    frame_n = 1'b0;
    tick();
    for (int i = 10; i >= 6; i--) begin
      bit_vld = 1'b1;
      bit_in  = w[i];
      tick();
    end
    bit_vld = 1'b0;
    frame_n = 1'b1;
    tick();
    check("abort_err", err, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_dout", d_out, 8'hA5);
    tick();
    check("abort_err_drop", err, 1'b0);
    check("abort_err_cycles", 32'(n_err_cyc - b_err), 1);
    check("abort_no_strobe", 32'((n_enh_cyc - b_enh) + (n_clrh_cyc - b_clrh)), 0);
    send_frame(1'b0, 2'd1, 8'h5A, 1'b0);
    check("post_abort_enh", enh, 4'b0010);
    check("post_abort_dout", d_out, 8'h5A);
    end_frame();

    // Clear addr=1 data=FF, gapped bits
    b_enh = n_enh_cyc; b_clrh = n_clrh_cyc; b_err = n_err_cyc;
    send_frame(1'b1, 2'd1, 8'hFF, 1'b1);
    check("clr_clrh", clrh, 4'b0010);
    check("clr_enh", enh, 4'b0000);
    check("clr_dout", d_out, 8'hFF);
    end_frame();
    check("clr_clrh_cycles", 32'(n_clrh_cyc - b_clrh), 1);
    check("clr_no_enh", 32'(n_enh_cyc - b_enh), 0);
    check("clr_no_err", 32'(n_err_cyc - b_err), 0);

    // Async reset while idle
    tick();
    #2 rstn = 1'b0;
    #1;
    check("idle_rst_dout", d_out, 8'h00);
    check("idle_rst_busy", busy, 1'b0);
    #1 rstn = 1'b1;
    tick();

    // Out of range on the 3-register instance, extra bits ignored
    b_enh = n_enh_cyc; b_err3 = n_err3_cyc;
    send_frame(1'b0, 2'd3, 8'h77, 1'b0);
    check("oor_err3", err3, 1'b1);
    check("oor_enh3", enh3, 3'b000);
    check("oor_clrh3", clrh3, 3'b000);
    check("oor_dout3", d_out3, 8'h77);
    check("oor_enh4", enh, 4'b1000);
    check("oor_err4", err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bit_vld = 1'b1;
      bit_in  = i[0];
      tick();
    end
    check("oor_extra_busy", busy3, 1'b1);
    check("oor_extra_dout", d_out, 8'h77);
    end_frame();
    check("oor_err3_cycles", 32'(n_err3_cyc - b_err3), 1);
    check("oor_enh_cycles", 32'(n_enh_cyc - b_enh), 1);

    // Reset during DATA discards the frame
    b_enh = n_enh_cyc;
    w = {1'b0, 2'd2, 8'hC3};
    frame_n = 1'b0;
    tick();
    for (int i = 10; i >= 5; i--) begin
      bit_vld = 1'b1;
      bit_in  = w[i];
      tick();
    end
    bit_vld = 1'b0;
    frame_n = 1'b1;
    rstn    = 1'b0;
    #2;
    check("mid_rst_dout", d_out, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    #2 rstn = 1'b1;
    tick();
    check("mid_rst_idle", busy, 1'b0);
    check("mid_rst_no_strobe", 32'(n_enh_cyc - b_enh), 0);
    send_frame(1'b0, 2'd0, 8'h3C, 1'b0);
    check("after_rst_enh", enh, 4'b0001);
    check("after_rst_dout", d_out, 8'h3C);
    end_frame();

    tick();
    check("onehot_violations", n_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
